// File: rtl/dm_port_server_pkg.sv
// Shared definitions for the data-memory port server and the processor top.
package dm_port_pkg;

    localparam int unsigned DEF_NCORES = 4;
    localparam int unsigned DEF_AW     = 16;
    localparam int unsigned DEF_DW     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Width of a core index; at least one bit so a single-core build still elaborates.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dm_port_server_if.sv
// Core-side and RAM-side signal bundle of the data-memory port server.
interface dm_port_server_if
    import dm_port_pkg::*;
#(
    parameter int unsigned NCORES = DEF_NCORES,
    parameter int unsigned AW     = DEF_AW,
    parameter int unsigned DW     = DEF_DW
) ();

    logic [NCORES-1:0]    core_req;
    logic [NCORES-1:0]    core_we;
    logic [NCORES*AW-1:0] core_addr;
    logic [NCORES*DW-1:0] core_wdata;
    logic [NCORES-1:0]    core_done;
    logic [NCORES*DW-1:0] core_rdata;
    logic [NCORES-1:0]    core_status;
    logic                 ram_en;
    logic                 ram_we;
    logic [AW-1:0]        ram_addr;
    logic [DW-1:0]        ram_wdata;
    logic [DW-1:0]        ram_rdata;
    logic                 all_done;
    logic                 busy;

    // Server side: the memory responder.
    modport slave (
        input  core_req, core_we, core_addr, core_wdata, core_done, ram_rdata,
        output core_rdata, core_status, ram_en, ram_we, ram_addr, ram_wdata,
        output all_done, busy
    );

    // Client side: cores plus the RAM.
    modport master (
        output core_req, core_we, core_addr, core_wdata, core_done, ram_rdata,
        input  core_rdata, core_status, ram_en, ram_we, ram_addr, ram_wdata,
        input  all_done, busy
    );

endinterface

// File: rtl/dm_port_server_rr_arbiter.sv
// Combinational round-robin picker: first eligible core after rr_ptr, wrapping.
module rr_arbiter
    import dm_port_pkg::*;
#(
    parameter int unsigned NCORES = DEF_NCORES,
    parameter int unsigned IW     = 2
) (
    input  logic [NCORES-1:0] eligible,
    input  logic [IW-1:0]     rr_ptr,
    output logic [IW-1:0]     grant,
    output logic              grant_valid
);

    logic [IW-1:0] cand;

    // Scan rr_ptr+1 .. rr_ptr+NCORES modulo NCORES; the first hit wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int unsigned i = 1; i <= NCORES; i++) begin
            cand = IW'((32'(rr_ptr) + i) % NCORES);
            if (!grant_valid && eligible[cand]) begin
                grant       = cand;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dm_port_server.sv
// Shared data-memory responder: round-robin arbitration of core requests
// onto one synchronous single-port RAM, plus a sticky global done flag.
module dm_port_server
    import dm_port_pkg::*;
#(
    parameter int unsigned NCORES = DEF_NCORES,
    parameter int unsigned AW     = DEF_AW,
    parameter int unsigned DW     = DEF_DW
) (
    input  logic             clk,
    input  logic             rst_n,
    dm_port_server_if.slave  bus
);

    localparam int unsigned IW = idx_width(NCORES);

    state_t               state;
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        gidx;
    logic [NCORES-1:0]    mask;
    logic [NCORES-1:0]    eligible;
    logic [NCORES-1:0]    g_onehot;
    logic [IW-1:0]        pick;
    logic                 pick_valid;
    logic                 acc_we;
    logic                 ram_en_q;
    logic                 ram_we_q;
    logic [AW-1:0]        ram_addr_q;
    logic [DW-1:0]        ram_wdata_q;
    logic [NCORES-1:0]    status_q;
    logic [NCORES*DW-1:0] rdata_q;
    logic                 all_done_q;

    // Requests still eligible after suppressing the core acked last cycle.
    always_comb begin
        eligible = bus.core_req & ~mask;
    end

    // One-hot form of the current grant index.
    always_comb begin
        g_onehot = NCORES'(1) << gidx;
    end

    rr_arbiter #(
        .NCORES (NCORES),
        .IW     (IW)
    ) u_arb (
        .eligible    (eligible),
        .rr_ptr      (rr_ptr),
        .grant       (pick),
        .grant_valid (pick_valid)
    );

    // Access sequencer: grant in IDLE, RAM cycle in ISSUE, return data/status in RESP.
    // acc_we keeps the access direction because ram_we is dropped after ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= IW'(NCORES - 1);
            gidx        <= '0;
            mask        <= '0;
            acc_we      <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            status_q    <= '0;
            rdata_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    status_q <= '0;
                    mask     <= '0;
                    if (pick_valid) begin
                        gidx        <= pick;
                        acc_we      <= bus.core_we[pick];
                        ram_we_q    <= bus.core_we[pick];
                        ram_addr_q  <= bus.core_addr[pick*AW +: AW];
                        ram_wdata_q <= bus.core_wdata[pick*DW +: DW];
                        ram_en_q    <= 1'b1;
                        state       <= ST_ISSUE;
                    end else begin
                        ram_en_q <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    ram_en_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (!acc_we) begin
                        rdata_q[gidx*DW +: DW] <= bus.ram_rdata;
                    end
                    status_q <= g_onehot;
                    rr_ptr   <= gidx;
                    mask     <= g_onehot;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky completion flag, set once every core reports end_process.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_done_q <= 1'b0;
        end else if (&bus.core_done) begin
            all_done_q <= 1'b1;
        end
    end

    assign bus.ram_en      = ram_en_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.core_status = status_q;
    assign bus.core_rdata  = rdata_q;
    assign bus.all_done    = all_done_q;
    assign bus.busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_dm_port_server.sv
// Directed bench for dm_port_server with a transaction-level reference model.
module tb_dm_port_server;

    localparam int unsigned NC = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    dm_port_server_if #(.NCORES(NC), .AW(AW), .DW(DW)) bus ();

    dm_port_server #(.NCORES(NC), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // Power-up contents of memory locations never written.
    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a == 16'h0010) return 16'h1234;
        return a ^ 16'h5A00;
    endfunction

    // Synchronous single-port RAM, 1 KiW window.
    bit [15:0]   mem [0:1023];
    bit [1023:0] written;
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) begin
                mem[bus.ram_addr[9:0]]     <= bus.ram_wdata;
                written[bus.ram_addr[9:0]] <= 1'b1;
            end else begin
                bus.ram_rdata <= written[bus.ram_addr[9:0]] ? mem[bus.ram_addr[9:0]]
                                                           : init_val(bus.ram_addr);
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    int          m_k;
    bit          m_pend;
    int          m_gk;
    int          m_core;
    bit          m_we;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    int          m_last;
    bit          m_justdone;
    logic [3:0]  m_elig;
    logic [3:0]  e_status;
    logic [15:0] e_rdata [NC];
    bit          e_ram_en;
    bit          e_busy;
    bit          e_all_done;
    logic [15:0] shadow [int];
    int          log_core[$];
    int          log_cyc[$];
    int          log_ones[$];

    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_k = 0; m_pend = 0; m_last = NC - 1; m_justdone = 0;
            e_status = '0; e_ram_en = 0; e_busy = 0; e_all_done = 0;
            for (int i = 0; i < NC; i++) e_rdata[i] = '0;
        end else begin
            m_k++;
            e_status = '0;
            e_ram_en = 0;
            if (&bus.core_done) e_all_done = 1;
            if (m_pend) begin
                if (m_k == m_gk + 2) begin
                    e_status[m_core] = 1'b1;
                    if (m_we) shadow[int'(m_addr)] = m_wdata;
                    else e_rdata[m_core] = shadow.exists(int'(m_addr)) ? shadow[int'(m_addr)]
                                                                       : init_val(m_addr);
                    m_last = m_core; m_justdone = 1; m_pend = 0;
                end
            end else begin
                m_elig = bus.core_req;
                if (m_justdone) m_elig[m_last] = 1'b0;
                m_justdone = 0;
                for (int i = 1; i <= NC; i++) begin
                    int c;
                    c = (m_last + i) % NC;
                    if (!m_pend && m_elig[c]) begin
                        m_pend = 1; m_gk = m_k; m_core = c;
                        m_we = bus.core_we[c];
                        m_addr = bus.core_addr[c*AW +: AW];
                        m_wdata = bus.core_wdata[c*DW +: DW];
                        e_ram_en = 1;
                    end
                end
            end
            e_busy = m_pend;

            chk("cyc_status", bus.core_status, e_status);
            for (int i = 0; i < NC; i++) chk($sformatf("cyc_rdata%0d", i), bus.core_rdata[i*DW +: DW], e_rdata[i]);
            chk("cyc_ram_en", bus.ram_en, e_ram_en);
            chk("cyc_ram_we", bus.ram_we, e_ram_en && m_we);
            chk("cyc_busy", bus.busy, e_busy);
            chk("cyc_all_done", bus.all_done, e_all_done);
            if (e_ram_en) begin
                chk("cyc_ram_addr", bus.ram_addr, m_addr);
                if (m_we) chk("cyc_ram_wdata", bus.ram_wdata, m_wdata);
            end
            if (bus.core_status != '0) begin
                for (int i = 0; i < NC; i++) if (bus.core_status[i]) log_core.push_back(i);
                log_cyc.push_back(m_k);
                log_ones.push_back($countones(bus.core_status));
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [3:0] hog;

    // Advance to the next falling edge; cores drop req once they see their status.
    task automatic step();
        @(negedge clk);
        bus.core_req = bus.core_req & ~(bus.core_status & ~hog);
    endtask

    task automatic set_req(input int c, input logic we, input logic [15:0] a, input logic [15:0] d);
        bus.core_req[c]            = 1'b1;
        bus.core_we[c]             = we;
        bus.core_addr[c*AW +: AW]  = a;
        bus.core_wdata[c*DW +: DW] = d;
    endtask

    task automatic wait_served(input int c, input int budget, input string name);
        int n = 0;
        do begin step(); n++; end while (!bus.core_status[c] && n < budget);
        chk(name, bus.core_status[c], 1);
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int n = 0;
        while (bus.core_req != '0 && n < budget) begin step(); n++; end
        chk(name, bus.core_req, 0);
        step();
    endtask

    initial begin
        int base;
        int n;
        rst_n = 1'b0; hog = '0;
        bus.core_req = '0; bus.core_we = '0; bus.core_addr = '0;
        bus.core_wdata = '0; bus.core_done = '0;
        repeat (2) @(negedge clk);
        chk("rst_ram_en", bus.ram_en, 0);
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_status", bus.core_status, 0);
        chk("rst_rdata", bus.core_rdata, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_all_done", bus.all_done, 0);
        rst_n = 1'b1;

        // Single read by core 1.
        step();
        set_req(1, 1'b0, 16'h0010, 16'h0000);
        step();
        chk("t1_ram_en_e0", bus.ram_en, 1);
        chk("t1_ram_addr", bus.ram_addr, 16'h0010);
        step();
        chk("t1_ram_en_e1", bus.ram_en, 0);
        step();
        chk("t1_status", bus.core_status, 4'b0010);
        chk("t1_rdata1", bus.core_rdata[31:16], 16'h1234);
        chk("t1_rdata_other", {bus.core_rdata[63:32], bus.core_rdata[15:0]}, 0);
        step();
        chk("t1_status_clear", bus.core_status, 0);

        // Write then read by core 0.
        set_req(0, 1'b1, 16'h0020, 16'hBEEF);
        step();
        chk("t2_ram_we", bus.ram_we, 1);
        chk("t2_ram_wdata", bus.ram_wdata, 16'hBEEF);
        step();
        step();
        chk("t2_wr_status", bus.core_status, 4'b0001);
        chk("t2_wr_rdata0", bus.core_rdata[15:0], 16'h0000);
        set_req(0, 1'b0, 16'h0020, 16'h0000);
        wait_served(0, 12, "t2_rd_served");
        chk("t2_rd_rdata0", bus.core_rdata[15:0], 16'hBEEF);
        step();

        // Contention from reset.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        base = log_core.size();
        for (int c = 0; c < NC; c++) set_req(c, 1'b0, 16'(16'h0100 + c), 16'h0000);
        n = 0;
        while (log_core.size() < base + 4 && n < 40) begin step(); n++; end
        chk("t3_pulses", log_core.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < log_core.size()) begin
                chk($sformatf("t3_order%0d", i), log_core[base+i], i);
                chk($sformatf("t3_onehot%0d", i), log_ones[base+i], 1);
                if (i > 0) chk($sformatf("t3_gap%0d", i), log_cyc[base+i] - log_cyc[base+i-1], 3);
            end
        end
        chk("t3_rdata3", bus.core_rdata[63:48], 16'h0103 ^ 16'h5A00);
        wait_quiet(10, "t3_quiet");

        // Hog prevention: core 2 holds req, core 3 asks once.
        base = log_core.size();
        hog = 4'b0100;
        set_req(2, 1'b0, 16'h0200, 16'h0000);
        step();
        set_req(3, 1'b0, 16'h0300, 16'h0000);
        n = 0;
        while (log_core.size() < base + 3 && n < 40) begin step(); n++; end
        chk("t4_pulses", log_core.size() - base, 3);
        if (log_core.size() >= base + 3) begin
            chk("t4_first", log_core[base], 2);
            chk("t4_second", log_core[base+1], 3);
            chk("t4_third", log_core[base+2], 2);
        end
        hog = '0;
        wait_quiet(20, "t4_quiet");

        // Sticky done, then reset during ISSUE.
        bus.core_done = 4'b1111;
        #1;
        chk("t5_done_before_edge", bus.all_done, 0);
        step();
        chk("t5_done_set", bus.all_done, 1);
        bus.core_done = 4'b0101;
        step();
        chk("t5_done_sticky1", bus.all_done, 1);
        step();
        chk("t5_done_sticky2", bus.all_done, 1);
        set_req(1, 1'b0, 16'h0010, 16'h0000);
        step();
        chk("t5_in_issue", bus.ram_en, 1);
        base = log_core.size();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ram_en", bus.ram_en, 0);
        chk("t5_rst_ram_we", bus.ram_we, 0);
        chk("t5_rst_all_done", bus.all_done, 0);
        chk("t5_rst_busy", bus.busy, 0);
        bus.core_req = '0;
        repeat (3) step();
        chk("t5_no_status", bus.core_status, 0);
        chk("t5_no_pulse", log_core.size() - base, 0);
        rst_n = 1'b1;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dm_port_server.md
Name: dm_port_server

Overview:
- Shared data-memory responder for the multicore matrix-multiply array.
- It is the memory-side end of each core's data-memory interface: address, write data, write strobe, read data and status.
- It arbitrates NCORES core requests round-robin onto one synchronous single-port RAM and returns read data and a one-cycle completion status to the granted core.
- It also collects per-core end_process flags into a global done flag.

Parameters:
- NCORES, 4, number of processor cores served.
- AW, 16, address width (matches core DAR width).
- DW, 16, data width (matches core bus width).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- core_req  in  NCORES  per-core access request; core holds it until its status pulse.
- core_we  in  NCORES  per-core write strobe (1 = write, 0 = read); valid while core_req is high.
- core_addr  in  NCORES*AW  flattened per-core address; core i occupies bits [i*AW +: AW].
- core_wdata  in  NCORES*DW  flattened per-core write data.
- core_done  in  NCORES  per-core end_process flag.
- core_rdata  out  NCORES*DW  flattened per-core registered read data.
- core_status  out  NCORES  per-core one-cycle completion pulse.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data, valid one cycle after the ram_en edge.
- all_done  out  1  sticky global completion flag.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; rr_ptr = NCORES-1; grant index = 0; mask = 0.
  - All outputs 0, including core_rdata, core_status, ram_*, all_done and busy.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - eligible = core_req & ~mask.
  - If eligible is nonzero: pick the first set bit searching upward from rr_ptr+1 and wrapping modulo NCORES.
  - Latch the grant index and that core's we/addr/wdata into ram_we, ram_addr, ram_wdata; set ram_en = 1; go to ISSUE.
  - If eligible is zero: stay in IDLE, ram_en = 0.
  - In either case, mask is cleared at this edge.
- ISSUE (one cycle, RAM samples ram_en/we/addr/wdata at the closing edge):
  - Deassert ram_en and ram_we; go to RESP.
- RESP:
  - For a read, core_rdata[g] <= ram_rdata. For a write, core_rdata[g] is unchanged.
  - core_status[g] <= 1 for exactly one cycle.
  - rr_ptr <= g; mask <= one-hot(g); go to IDLE.
- Latency:
  - A request sampled in IDLE at edge E0 produces its status pulse in the cycle after E2.
  - Minimum turnaround is 3 cycles per access.
  - Worst-case wait for any core is NCORES*3 + 2 cycles.
- Back-to-back masking: during the status cycle the acked core still holds core_req. The one-cycle mask stops it being re-granted on the stale request. Other cores are eligible in that same IDLE cycle.
- Core behaviour:
  - core_addr, core_wdata and core_we are sampled only at grant; later changes do not affect the access.
  - A core that drops core_req before its grant is simply not served. There is no abort once granted.
- Fairness: a core that keeps requesting cannot be granted twice in a row while any other core is requesting.
- all_done:
  - Set when core_done is all-ones at a rising edge (registered, so it rises one cycle later).
  - Remains set until reset, even if core_done bits later fall.
- Reset asserted mid-access: FSM returns to IDLE immediately, ram_en and ram_we drop asynchronously, and no status pulse is issued.
- core_status is all-zero except during a single RESP-to-IDLE cycle, when exactly one bit is set.

Decomposition:
- Shared package dm_port_pkg holds:
  - state encoding constants ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_RESP = 2'd2;
  - default NCORES, AW and DW values, shared with the processor top.
- One sub-module, rr_arbiter:
  - combinational NCORES-wide round-robin priority picker;
  - inputs: eligible vector, rr_ptr;
  - outputs: grant index, grant_valid.

Test Plan:
- Single read: ram[0x0010] = 0x1234; core 1 reads addr 0x0010.
  - ram_en high in the cycle after E0.
  - core_status[1] pulses in the cycle after E2.
  - core_rdata[1] = 0x1234; all other core_rdata unchanged.
- Write then read: core 0 writes 0xBEEF to 0x0020, then reads 0x0020.
  - RAM sees ram_we = 1 only on the write.
  - The read returns 0xBEEF.
  - core_rdata[0] is unchanged after the write.
- Contention: cores 0–3 all request at once from reset.
  - Grants occur in order 0, 1, 2, 3, one every 3 cycles.
  - Exactly one core_status bit is set per pulse.
- Hog prevention: core 2 holds core_req permanently and core 3 requests once.
  - Core 3 is served immediately after core 2's current access.
  - Core 2 is never granted twice in a row while core 3 is pending.
- Done and reset: core_done rises to 4'b1111, then drops.
  - all_done = 1 one cycle later and stays 1.
  - Asserting rst_n = 0 during ISSUE clears all_done and ram_en immediately, with no status pulse.
